// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: field encodings, unit counts, FSM states.
// Field layout: b2 = LAST, b1 = mark, b0 = dash-select (when marking).
// Imported by morse_keyer and morse_unit_timer.
package morse_pkg;

  localparam int FIELD_W    = 3;
  localparam int NUM_FIELDS = 8;
  localparam int WORD_W     = FIELD_W * NUM_FIELDS;
  localparam int FLD_W      = $clog2(NUM_FIELDS);
  localparam int UNITS_W    = 3;

  localparam logic [FIELD_W-1:0] DOT       = 3'b010;
  localparam logic [FIELD_W-1:0] DASH      = 3'b011;
  localparam logic [FIELD_W-1:0] LAST      = 3'b100;
  localparam logic [FIELD_W-1:0] BAD_FIELD = 3'b001;

  localparam logic [UNITS_W-1:0] DOT_UNITS      = 3'd1;
  localparam logic [UNITS_W-1:0] DASH_UNITS     = 3'd3;
  localparam logic [UNITS_W-1:0] ISG_UNITS      = 3'd1;
  localparam logic [UNITS_W-1:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [UNITS_W-1:0] WORD_GAP_UNITS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_MARK,
    ST_ISG,
    ST_CHARGAP,
    ST_WORDGAP
  } keyer_state_e;

  typedef struct packed {
    logic mark;
    logic dash;
    logic last;
    logic bad;
  } field_dec_t;

  function automatic field_dec_t decode_field(input logic [FIELD_W-1:0] f);
    field_dec_t d;
    d.mark = |(f & DOT);
    d.dash = |(f & (DASH & ~DOT));
    d.last = |(f & LAST);
    d.bad  = (f == BAD_FIELD);
    return d;
  endfunction

  function automatic logic field_is_mark(input logic [FIELD_W-1:0] f);
    return |(f & DOT);
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: asserts done during the last cycle of units*UNIT_CYCLES cycles
// counted from the cycle after clear. Latency: combinational done, no backpressure.
// Ports: clk, rst_n, clear (restart at 0 next cycle), units (count), done.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [UNITS_W-1:0] units,
  output logic               done
);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [UNITS_W-1:0] unit_q, unit_d;
  logic               unit_end;

  always_comb begin
    unit_end = (cyc_q == CYC_LAST);
    done     = unit_end && (unit_q == (units - UNITS_W'(1)));
    cyc_d    = cyc_q;
    unit_d   = unit_q;
    if (clear) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (unit_end) begin
      cyc_d  = '0;
      unit_d = unit_q + UNITS_W'(1);
    end else begin
      cyc_d  = cyc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      unit_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: serialises one packed 8x3-bit code word into an ITU-timed key line.
// Latency: key rises 2 + (leading skipped fields) cycles after the accepting cycle.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored (producer holds).
// Ports: clk, rst_n, in_valid/in_ready/in_morse (word in), key_out, busy, bad_field.
// Optional: define MORSE_KEYER_SIDETONE_EN to add TONE_HALF_CYCLES and tone_out.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000,
  parameter int CNT_W       = 16
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  parameter int TONE_HALF_CYCLES = 50
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_morse,
  output logic              key_out,
  output logic              busy,
  output logic              bad_field
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  output logic              tone_out
`endif
);

  keyer_state_e       state_q, state_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [FLD_W-1:0]   fld_q, fld_d;
  logic               key_q, key_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic               bad_q, bad_d;

  field_dec_t         top_dec;
  logic               nxt_mark;
  logic               last_fld;
  logic               tmr_clear;
  logic [UNITS_W-1:0] tmr_units;
  logic               tmr_done;

  // The field under examination is always the top of the shift register;
  // the one below it is peeked at the end of an intra-character gap.
  always_comb begin
    top_dec  = decode_field(sr_q[WORD_W-1 -: FIELD_W]);
    nxt_mark = field_is_mark(sr_q[WORD_W-FIELD_W-1 -: FIELD_W]);
    last_fld = (fld_q == FLD_W'(NUM_FIELDS - 1));
  end

  always_comb begin
    unique case (state_q)
      ST_MARK:    tmr_units = top_dec.dash ? DASH_UNITS : DOT_UNITS;
      ST_ISG:     tmr_units = ISG_UNITS;
      ST_CHARGAP: tmr_units = CHAR_GAP_UNITS;
      ST_WORDGAP: tmr_units = WORD_GAP_UNITS;
      default:    tmr_units = DOT_UNITS;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fld_d   = fld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && rdy_q) begin
          state_d = ST_SCAN;
          sr_d    = in_morse;
          fld_d   = '0;
        end
      end
      ST_SCAN: begin
        if (top_dec.mark) begin
          state_d = ST_MARK;
        end else if (top_dec.last) begin
          state_d = ST_WORDGAP;
        end else if (last_fld) begin
          state_d = ST_CHARGAP;
        end else begin
          sr_d  = sr_q << FIELD_W;
          fld_d = fld_q + FLD_W'(1);
        end
      end
      ST_MARK: begin
        if (tmr_done) state_d = top_dec.last ? ST_CHARGAP : ST_ISG;
      end
      ST_ISG: begin
        // A following mark is keyed straight from here so the gap between
        // two marks is exactly one unit; anything else is left to SCAN.
        if (tmr_done) begin
          if (last_fld) begin
            state_d = ST_CHARGAP;
          end else begin
            sr_d    = sr_q << FIELD_W;
            fld_d   = fld_q + FLD_W'(1);
            state_d = nxt_mark ? ST_MARK : ST_SCAN;
          end
        end
      end
      ST_CHARGAP, ST_WORDGAP: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    key_d  = (state_d == ST_MARK);
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
    bad_d  = (state_q == ST_SCAN) && top_dec.bad;
  end

  // Every state change restarts the unit timer, so each timed state lasts
  // exactly units * UNIT_CYCLES cycles.
  assign tmr_clear = (state_d != state_q);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .units (tmr_units),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      fld_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fld_q   <= fld_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      bad_q   <= bad_d;
    end
  end

  assign in_ready  = rdy_q;
  assign key_out   = key_q;
  assign busy      = busy_q;
  assign bad_field = bad_q;

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int TONE_W = 16;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_CYCLES - 1);

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;

  // Held at zero while the key is up, so each key rise starts a fresh phase.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (!key_q) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      tone_cnt_d = tone_cnt_q + TONE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign tone_out = tone_q & key_q;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
`timescale 1ns/1ps
module tb_morse_keyer;

  localparam int U = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_morse = '0;
  logic        in_ready, key_out, busy, bad_field;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_trace[$];
  bit obs_trace[$];
  int exp_bad;

  morse_keyer #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_morse  (in_morse),
    .key_out   (key_out),
    .busy      (busy),
    .bad_field (bad_field)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_lvl(input bit lvl, input int n);
    for (int k = 0; k < n; k++) exp_trace.push_back(lvl);
  endtask

  // Reference: key level for every cycle after the accepting cycle until the
  // keyer is ready again. Each scanned field costs one cycle; marks last 1 or
  // 3 units; consecutive marks are one unit apart; a char ends with 3 units
  // low, a space field with 4 units low.
  task automatic model(input logic [23:0] w);
    bit after_gap;
    logic [2:0] f;
    after_gap = 1'b0;
    exp_trace.delete();
    exp_bad = 0;
    for (int i = 0; i < 8; i++) begin
      f = w[23-3*i -: 3];
      if (f[1]) begin
        if (!after_gap) push_lvl(1'b0, 1);
        push_lvl(1'b1, f[0] ? 3*U : U);
        if (f[2]) begin push_lvl(1'b0, 3*U); return; end
        push_lvl(1'b0, U);
        if (i == 7) begin push_lvl(1'b0, 3*U); return; end
        after_gap = 1'b1;
      end else begin
        push_lvl(1'b0, 1);
        if (f == 3'b001) exp_bad++;
        if (f[2]) begin push_lvl(1'b0, 4*U); return; end
        if (i == 7) begin push_lvl(1'b0, 3*U); return; end
        after_gap = 1'b0;
      end
    end
  endtask

  // Compare key waveforms as run lists, each run encoded len*2+level.
  task automatic cmp_runs(input string tag);
    int er[$];
    int orr[$];
    int m;
    for (int i = 0; i < exp_trace.size(); i++)
      if (i == 0 || exp_trace[i] != exp_trace[i-1]) er.push_back(2 + int'(exp_trace[i]));
      else er[er.size()-1] += 2;
    for (int i = 0; i < obs_trace.size(); i++)
      if (i == 0 || obs_trace[i] != obs_trace[i-1]) orr.push_back(2 + int'(obs_trace[i]));
      else orr[orr.size()-1] += 2;
    chk({tag, "_nruns"}, orr.size(), er.size());
    m = (orr.size() < er.size()) ? orr.size() : er.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_run%0d(len*2+lvl)", tag, i), orr[i], er[i]);
  endtask

  task automatic send(input string tag, input logic [23:0] w, input bit garble);
    int budget;
    int cyc;
    int obs_bad;
    int obs_busy;
    int len;
    model(w);
    len = exp_trace.size();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    budget = 0;
    while (in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_ready_before"}, int'(in_ready), 1);
    in_morse = w;
    in_valid = 1'b1;
    @(negedge clk);
    obs_trace.delete();
    obs_bad = 0;
    obs_busy = 0;
    cyc = 0;
    while (cyc < len + 40) begin
      if (in_ready === 1'b1) break;
      obs_trace.push_back(key_out);
      obs_bad += int'(bad_field);
      obs_busy += int'(busy);
      // Offer junk while busy: it must be neither accepted nor sampled.
      if (garble && cyc < len - 3) begin
        in_valid = 1'b1;
        in_morse = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_len"}, obs_trace.size(), len);
    chk({tag, "_busy_cycles"}, obs_busy, len);
    chk({tag, "_bad_pulses"}, obs_bad, exp_bad);
    cmp_runs(tag);
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    logic [2:0]  f;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 9))
        0: f = 3'b000;
        1: f = 3'b001;
        2, 3, 9: f = 3'b010;
        4, 5: f = 3'b011;
        6: f = 3'b110;
        7: f = 3'b111;
        default: f = 3'b100;
      endcase
      w[23-3*i -: 3] = f;
    end
    return w;
  endfunction

  task automatic reset_mid_dash();
    while (in_ready !== 1'b1) @(negedge clk);
    in_morse = 24'hE00000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("dash_key_on", int'(key_out), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_key", int'(key_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    logic [23:0] err_word;
    for (int i = 0; i < 7; i++) err_word[23-3*i -: 3] = 3'b010;
    err_word[2:0] = 3'b110;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_key", int'(key_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bad", int'(bad_field), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(in_ready), 1);

    send("E", 24'hC00000, 1'b0);
    send("A", 24'h5C0000, 1'b1);
    send("space", 24'h100000, 1'b0);
    send("err8", err_word, 1'b0);
    send("badf", 24'h240000, 1'b1);
    send("zero", 24'h000000, 1'b0);

    reset_mid_dash();
    send("T", 24'hE00000, 1'b0);

    for (int n = 0; n < 40; n++)
      send($sformatf("rnd%0d", n), rand_word(), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
